ame_num_sched: RTL
==================

AME_NUM_SCHED -- requirements
Module: ame_num_sched

Interface
REQ-001 Parameter COMP_DATA_BITS, default 64, SHALL set the operand and result width.
REQ-002 Parameter REQ_NUM, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT cycles before abort.
REQ-004 The port list SHALL be as follows, one port per entry, clock and reset first:
- clk_i  in  1  the single clock; all logic is on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  REQ_NUM  per-requester operand valid.
- req_ready_o  out  REQ_NUM  per-requester grant/accept, at most one bit high.
- req_data_i  in  REQ_NUM x 4 x COMP_DATA_BITS  operands per requester, ordered {M, D, L, C}.
- rsp_valid_o  out  REQ_NUM  one-hot result valid, identifying the owning requester.
- rsp_ready_i  in  1  result accepted.
- rsp_data_o  out  COMP_DATA_BITS  result M*D-L*C, truncated to COMP_DATA_BITS.
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o.
- comp_init_o  out  1  start pulse to the shared numerator unit.
- comp_data_o  out  4 x COMP_DATA_BITS  latched operands {M, D, L, C} to the unit.
- comp_done_i  in  1  unit done.
- comp_data_i  in  COMP_DATA_BITS  unit result.

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-006 In IDLE, req_ready_o SHALL be driven combinationally high for exactly one requester: the first valid one at or after rr_ptr, in cyclic order; all other bits low.
REQ-007 In ISSUE, WAIT and RESP, req_ready_o SHALL be all zero.
REQ-008 On accept (valid&&ready, cycle T), the block SHALL latch the operands into comp_data_o and the owner index, and enter ISSUE.
REQ-009 At accept, rr_ptr SHALL become (owner+1) mod REQ_NUM.
REQ-010 ISSUE SHALL last one cycle with comp_init_o=1, then enter WAIT; comp_init_o SHALL be 0 in every other state.
REQ-011 comp_data_o SHALL hold stable from ISSUE until the block returns to IDLE.
REQ-012 In WAIT, comp_done_i=1 SHALL latch comp_data_i into rsp_data_o, clear rsp_err_o and enter RESP.
- With a 1-cycle unit: ISSUE at T+1, done at T+2, rsp_valid_o at T+3.
REQ-013 A WAIT cycle counter SHALL start at 0 on WAIT entry.
REQ-014 If the counter reaches TIMEOUT without comp_done_i, the block SHALL enter RESP with rsp_data_o=0 and rsp_err_o=1.
- comp_done_i and the timeout in the same cycle: done wins.
REQ-015 comp_done_i outside WAIT SHALL be ignored, with no state or data change.
REQ-016 In RESP, rsp_valid_o SHALL be one-hot at the owner index, with rsp_data_o and rsp_err_o held stable until rsp_ready_i=1.
REQ-017 A response handshake SHALL return the FSM to IDLE on the next cycle; a new accept is possible in that IDLE cycle.
REQ-018 Minimum issue interval SHALL be 4 cycles; no overlapping transactions.
REQ-019 Deasserting req_valid_i after accept SHALL NOT affect the transaction in flight.

Reset
REQ-020 While rst_i=1 at a clock edge, the block SHALL go to IDLE and clear rr_ptr, the owner index, the WAIT counter, comp_init_o, comp_data_o, rsp_valid_o, rsp_data_o and rsp_err_o to 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction silently: no response, and a later comp_done_i is ignored.
REQ-022 req_ready_o SHALL be 0 while rst_i=1.

Structure
REQ-023 Package ame_pkg SHALL hold the FSM state typedef (enum ame_sched_state_t) and the default width constant AME_COMP_DATA_BITS=64.
REQ-024 Grant selection SHALL be a sub-module ame_rr_arbiter (REQ_NUM requests plus pointer in, one-hot grant and index out, purely combinational), instantiated once.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Requester 0 sends M=5,D=7,L=3,C=4 at T with a 1-cycle unit model -> comp_init_o at T+1; rsp_valid_o=0001, rsp_data_o=23 at T+3.
- All 4 requesters valid continuously from reset -> grants 0,1,2,3,0 in order, one every 4 cycles with rsp_ready_i tied high.
- M=0,D=0,L=1,C=1 -> rsp_data_o=all-ones (-1 two's complement), rsp_err_o=0.
- Unit never asserts done -> rsp_valid_o after TIMEOUT WAIT cycles with rsp_data_o=0, rsp_err_o=1; a later stray comp_done_i is ignored.
- rsp_ready_i held low 10 cycles -> rsp_valid_o/rsp_data_o stable, req_ready_o=0 throughout; IDLE on the cycle after ready.
- rst_i asserted during WAIT -> all outputs 0 the next cycle, rr_ptr=0, no response issued.

Source files
------------

// File: rtl/ame_pkg.sv
// Shared types and constants for the numerator scheduler.
package ame_pkg;

    localparam int unsigned AME_COMP_DATA_BITS = 64;
    localparam int unsigned AME_NUM_OPS        = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } ame_sched_state_t;

endpackage

// File: rtl/ame_num_sched_if.sv
// Requester/response bus of the numerator scheduler.
interface ame_num_sched_if
    import ame_pkg::*;
#(
    parameter int unsigned COMP_DATA_BITS = AME_COMP_DATA_BITS,
    parameter int unsigned REQ_NUM        = 4
);
    logic [REQ_NUM-1:0]                                   req_valid;
    logic [REQ_NUM-1:0]                                   req_ready;
    logic [REQ_NUM-1:0][AME_NUM_OPS-1:0][COMP_DATA_BITS-1:0] req_data;
    logic [REQ_NUM-1:0]                                   rsp_valid;
    logic                                                 rsp_ready;
    logic [COMP_DATA_BITS-1:0]                            rsp_data;
    logic                                                 rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ame_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr_i, cyclically.
module ame_rr_arbiter #(
    parameter  int unsigned REQ_NUM = 4,
    localparam int unsigned IDX_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [REQ_NUM-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    int unsigned cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            cand = (32'(ptr_i) + i) % REQ_NUM;
            if (!vld_o && req_i[IDX_W'(cand)]) begin
                vld_o               = 1'b1;
                idx_o               = IDX_W'(cand);
                gnt_o[IDX_W'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ame_num_sched.sv
// Arbitrates requesters onto one shared M*D-L*C unit, one transaction at a time,
// with a bounded wait for the unit and a per-owner one-hot response.
module ame_num_sched
    import ame_pkg::*;
#(
    parameter int unsigned COMP_DATA_BITS = AME_COMP_DATA_BITS,
    parameter int unsigned REQ_NUM        = 4,
    parameter int unsigned TIMEOUT        = 15
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [REQ_NUM-1:0]                                req_valid_i,
    output logic [REQ_NUM-1:0]                                req_ready_o,
    input  logic [REQ_NUM-1:0][AME_NUM_OPS-1:0][COMP_DATA_BITS-1:0] req_data_i,
    output logic [REQ_NUM-1:0]                                rsp_valid_o,
    input  logic                                              rsp_ready_i,
    output logic [COMP_DATA_BITS-1:0]                         rsp_data_o,
    output logic                                              rsp_err_o,
    output logic                                              comp_init_o,
    output logic [AME_NUM_OPS-1:0][COMP_DATA_BITS-1:0]        comp_data_o,
    input  logic                                              comp_done_i,
    input  logic [COMP_DATA_BITS-1:0]                         comp_data_i
);

    localparam int unsigned IDX_W = $clog2(REQ_NUM);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    ame_sched_state_t                           state_q, state_d;
    logic [IDX_W-1:0]                           owner_q, owner_d;
    logic [IDX_W-1:0]                           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                           cnt_q, cnt_d;
    logic                                       comp_init_q, comp_init_d;
    logic [AME_NUM_OPS-1:0][COMP_DATA_BITS-1:0] comp_data_q, comp_data_d;
    logic [REQ_NUM-1:0]                         rsp_valid_q, rsp_valid_d;
    logic [COMP_DATA_BITS-1:0]                  rsp_data_q, rsp_data_d;
    logic                                       rsp_err_q, rsp_err_d;

    logic [REQ_NUM-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;
    logic [REQ_NUM-1:0] owner_oh;

    ame_rr_arbiter #(.REQ_NUM(REQ_NUM)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    assign owner_oh    = REQ_NUM'(1) << owner_q;
    assign req_ready_o = (state_q == ST_IDLE && !rst_i) ? arb_gnt : '0;

    // Next-state and datapath; done is only honoured in WAIT and beats the timeout.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        comp_data_d = comp_data_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        comp_init_d = 1'b0;
        rsp_valid_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    owner_d     = arb_idx;
                    comp_data_d = req_data_i[arb_idx];
                    rr_ptr_d    = (arb_idx == IDX_W'(REQ_NUM - 1)) ? '0 : arb_idx + IDX_W'(1);
                    comp_init_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (comp_done_i) begin
                    rsp_data_d  = comp_data_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = owner_oh;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = owner_oh;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            comp_init_q <= 1'b0;
            comp_data_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            comp_init_q <= comp_init_d;
            comp_data_q <= comp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign comp_init_o = comp_init_q;
    assign comp_data_o = comp_data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
